// File: rtl/prog_updown_counter_nch.sv
// prog_updown_counter_nch: multi-channel programmable up/down counter with register bus.
// Define UDC_BOUNCE_EN to make CTRL.bit2 reverse direction at LIMIT.
module prog_updown_counter_nch #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int AW = $clog2(NCH) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ncs,
  input  logic                 nwr,
  input  logic                 nrd,
  input  logic [AW-1:0]        a,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       ec,
  output logic                 err
);
  localparam int CW = AW - 2;
  localparam int NS = 2 ** CW;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`ifdef UDC_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  logic [CW-1:0] ch;
  logic [1:0] rg;
  logic wr, rd, bad;
  logic [NS-1:0] running;
  logic [WIDTH-1:0] rd_val [NS];
  assign ch = a[AW-1:2];
  assign rg = a[1:0];
  assign wr = !ncs && !nwr && nrd;
  assign rd = !ncs && !nrd && nwr;
  assign bad = (!ncs && !nwr && !nrd) || (wr && rg == 2'd3) || (wr && rg == 2'd2 && running[ch]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
      dout <= '0;
    end else begin
      err <= bad;
      dout <= rd ? rd_val[ch] : '0;
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t state, state_nx;
    logic [WIDTH-1:0] load, limit, cnt, cnt_nx;
    logic [3:0] ctrl;
    logic d, d_nx, sticky, ec_q, sel, we, go, rl, bn, hit, up;
    assign sel = ch == CW'(c);
    assign we = wr && !bad && sel;
    assign go = start && ctrl[3];
    assign rl = ctrl[1];
    assign bn = BOUNCE && ctrl[2];
    assign hit = state == RUN && cnt == limit;
    // reload outranks bounce; start outranks everything and uses pre-edge registers
    assign up = (hit && bn) ? !d : d;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
    end
    always_comb state_nx = go ? RUN : (hit && !rl && !bn) ? DONE : state;
    always_comb begin
      cnt_nx = go ? load : state != RUN ? cnt : (hit && rl) ? load : (hit && !bn) ? cnt : up ? cnt + ONE : cnt - ONE;
      d_nx = go ? ctrl[0] : (hit && !rl && bn) ? !d : d;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        d <= 1'b0;
        ec_q <= 1'b0;
        sticky <= 1'b0;
      end else begin
        cnt <= cnt_nx;
        d <= d_nx;
        ec_q <= hit;
        sticky <= hit || (sticky && !(rd && sel && rg == 2'd3));
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        load <= '0;
        limit <= '0;
        ctrl <= '0;
      end else begin
        if (we && rg == 2'd0) load <= din;
        if (we && rg == 2'd1) limit <= din;
        if (we && rg == 2'd2) ctrl <= {din[3], BOUNCE & din[2], din[1:0]};
      end
    end
    // a STATUS read coinciding with a new end-count already reports it
    assign rd_val[c] = rg == 2'd0 ? load : rg == 2'd1 ? limit : rg == 2'd2 ? WIDTH'(ctrl) :
                       WIDTH'({d, sticky || hit, state == RUN});
    assign running[c] = state == RUN;
    assign count[c*WIDTH +: WIDTH] = cnt;
    assign dir[c] = d;
    assign ec[c] = ec_q;
  end
  for (genvar c = NCH; c < NS; c++) begin : g_pad
    assign running[c] = 1'b0;
    assign rd_val[c] = '0;
  end
endmodule

// File: tb/tb_prog_updown_counter_nch.sv
// tb_prog_updown_counter_nch: scoreboard bench; expectations queued by cycle, checked at negedge.
module tb_prog_updown_counter_nch;
  localparam int W = 8;
  localparam int N = 4;
  localparam int AW = 4;
`ifdef UDC_BOUNCE_EN
  localparam int BNC = 1;
`else
  localparam int BNC = 0;
`endif
  logic clk = 1'b0;
  logic rst, start, ncs, nwr, nrd, err;
  logic [AW-1:0] a;
  logic [W-1:0] din, dout;
  logic [N*W-1:0] count;
  logic [N-1:0] dir, ec;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int k;
  int v[$];
  typedef struct {int at; int sel; int ch; int val; string name;} exp_t;
  exp_t sb[$];

  prog_updown_counter_nch #(.WIDTH(W), .NCH(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .ncs(ncs), .nwr(nwr), .nrd(nrd),
    .a(a), .din(din), .dout(dout), .count(count), .dir(dir), .ec(ec), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(int sel, int ch);
    case (sel)
      0: return int'(dout);
      1: return int'(count[ch*W +: W]);
      2: return int'(dir[ch]);
      3: return int'(ec[ch]);
      default: return int'(err);
    endcase
  endfunction

  task automatic check(string nm, int act, int val);
    checks++;
    if (act != val) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, val, cyc);
    end
  endtask

  task automatic expect_at(int at, int sel, int ch, int val, string nm);
    exp_t e;
    int i = 0;
    e = '{at, sel, ch, val, nm};
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_cnt(int at, int ch, string nm);
    foreach (v[i]) expect_at(at + i, 1, ch, v[i], $sformatf("%s%0d", nm, i));
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: cycle %0d passed unchecked", e.name, e.at);
      end else check(e.name, sample(e.sel, e.ch), e.val);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [W-1:0] d);
    a = ad; din = d; ncs = 1'b0; nwr = 1'b0; nrd = 1'b1;
    tick();
    ncs = 1'b1; nwr = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] ad, input int val, input string nm);
    a = ad; ncs = 1'b0; nrd = 1'b0; nwr = 1'b1;
    expect_at(cyc + 1, 0, 0, val, nm);
    tick();
    ncs = 1'b1; nrd = 1'b1;
  endtask

  task automatic pulse;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ncs = 1'b1; nwr = 1'b1; nrd = 1'b1; a = '0; din = '0;
    idle(2);
    for (int c = 0; c < N; c++) begin
      expect_at(cyc + 1, 1, c, 0, "rst_cnt");
      expect_at(cyc + 1, 2, c, 0, "rst_dir");
      expect_at(cyc + 1, 3, c, 0, "rst_ec");
    end
    expect_at(cyc + 1, 0, 0, 0, "rst_dout");
    expect_at(cyc + 1, 4, 0, 0, "rst_err");
    idle(1);
    rst = 1'b0;
    // one-shot up on ch0, with a STATUS read landing on the end-count edge
    wr(4'h0, 8'h05); wr(4'h1, 8'h08); wr(4'h2, 8'h09);
    rd(4'h0, 8'h05, "ld0");
    rd(4'h2, 8'h09, "ctrl0");
    k = cyc;
    v = '{5, 6, 7, 8, 8, 8};
    exp_cnt(k + 1, 0, "up_cnt");
    expect_at(k + 3, 2, 0, 1, "up_dir");
    expect_at(k + 4, 3, 0, 0, "up_ec_pre");
    expect_at(k + 5, 3, 0, 1, "up_ec");
    expect_at(k + 6, 3, 0, 0, "up_ec_post");
    pulse();
    idle(3);
    rd(4'h3, 8'h07, "st0_hit");
    rd(4'h3, 8'h06, "st0_done");
    rd(4'h3, 8'h04, "st0_clr");
    expect_at(cyc + 1, 0, 0, 0, "dout_idle");
    idle(1);
    // ch1 down with wrap and reload; illegal accesses while counting
    wr(4'h4, 8'h01); wr(4'h5, 8'hFE); wr(4'h6, 8'h0A);
    k = cyc;
    v = '{1, 0, 255, 254, 1, 0, 255, 254, 1};
    exp_cnt(k + 1, 1, "dn_cnt");
    expect_at(k + 2, 2, 1, 0, "dn_dir");
    expect_at(k + 4, 3, 1, 0, "dn_ec_pre");
    expect_at(k + 5, 3, 1, 1, "dn_ec1");
    expect_at(k + 6, 3, 1, 0, "dn_ec_post");
    expect_at(k + 8, 3, 1, 0, "dn_ec_pre2");
    expect_at(k + 9, 3, 1, 1, "dn_ec2");
    expect_at(k + 2, 4, 0, 1, "err_ctrl_run");
    expect_at(k + 3, 4, 0, 0, "err_ctrl_run_end");
    expect_at(k + 3, 1, 0, 7, "ch0_still_run");
    expect_at(k + 4, 4, 0, 1, "err_wr_status");
    expect_at(k + 5, 4, 0, 0, "err_wr_status_end");
    expect_at(k + 6, 4, 0, 1, "err_rd_wr");
    expect_at(k + 6, 0, 0, 0, "dout_rd_wr");
    expect_at(k + 7, 4, 0, 0, "err_rd_wr_end");
    pulse();
    wr(4'h2, 8'h00);
    idle(1);
    wr(4'h7, 8'hFF);
    idle(1);
    a = 4'h4; din = 8'h77; ncs = 1'b0; nwr = 1'b0; nrd = 1'b0;
    tick();
    ncs = 1'b1; nwr = 1'b1; nrd = 1'b1;
    idle(3);
    rd(4'h2, 8'h09, "ctrl0_kept");
    rd(4'h4, 8'h01, "ld1_kept");
    rd(4'h7, 8'h03, "st1_run");
    // ch2 bounce (or plain one-shot when bounce is compiled out)
    wr(4'h8, 8'h10); wr(4'h9, 8'h12); wr(4'hA, 8'h0D);
    rd(4'hA, BNC ? 8'h0D : 8'h09, "ctrl2");
    k = cyc;
    if (BNC != 0) begin
      v = '{16, 17, 18, 17, 16, 15};
      expect_at(k + 4, 2, 2, 0, "bn_dir_after");
    end else begin
      v = '{16, 17, 18, 18, 18, 18};
      expect_at(k + 4, 2, 2, 1, "bn_dir_after");
    end
    exp_cnt(k + 1, 2, "bn_cnt");
    expect_at(k + 3, 2, 2, 1, "bn_dir_before");
    expect_at(k + 4, 3, 2, 1, "bn_ec");
    expect_at(k + 5, 3, 2, 0, "bn_ec_post");
    pulse();
    idle(5);
    // ch0 disabled holds through start; ch3 reset mid-run
    wr(4'h2, 8'h01);
    wr(4'hC, 8'h3E); wr(4'hD, 8'h00); wr(4'hE, 8'h09);
    k = cyc;
    v = '{62, 63};
    exp_cnt(k + 1, 3, "rr_cnt");
    expect_at(k + 1, 1, 0, 8, "en0_hold1");
    expect_at(k + 2, 1, 0, 8, "en0_hold2");
    pulse();
    idle(2);
    check("rr_pre", int'(count[3*W +: W]), 8'h40);
    #2 rst = 1'b1;
    #1;
    check("rr_cnt_async", int'(count[3*W +: W]), 0);
    check("rr_dir_async", int'(dir), 0);
    check("rr_all_cnt_async", int'(count), 0);
    idle(2);
    rst = 1'b0;
    wr(4'hE, 8'h09);
    rd(4'hE, 8'h09, "ctrl3_first_wr");
    rd(4'hC, 8'h00, "ld3_rst");
    rd(4'hF, 8'h00, "st3_idle");
    // LOAD == LIMIT fires on the first compare; ch2 left disabled by reset
    k = cyc;
    expect_at(k + 1, 1, 3, 0, "eq_cnt");
    expect_at(k + 1, 2, 3, 1, "eq_dir");
    expect_at(k + 1, 3, 3, 0, "eq_ec_pre");
    expect_at(k + 2, 3, 3, 1, "eq_ec");
    expect_at(k + 3, 3, 3, 0, "eq_ec_post");
    expect_at(k + 2, 1, 2, 0, "en2_off_hold");
    pulse();
    idle(2);
    rd(4'hF, 8'h06, "st3_done");
    idle(3);
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never checked", sb[0].name);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_updown_counter_nch.md
PROG_UPDOWN_COUNTER_NCH -- requirements
Module: prog_updown_counter_nch

Interface
REQ-001 Parameters SHALL be as follows:
- WIDTH, 8: counter, data and register width.
- NCH, 4: number of independent counter channels.
- AW, $clog2(NCH)+2: address width.
REQ-002 The block SHALL have one clock, clk; reset SHALL be rst, asynchronous and active-high.
REQ-003 Ports SHALL be as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  async active-high reset.
- start  input  1  start pulse for all channels with CTRL.en=1.
- ncs  input  1  active-low chip select.
- nwr  input  1  active-low write strobe.
- nrd  input  1  active-low read strobe.
- a  input  AW  register address; a[AW-1:2] is the channel, a[1:0] is the register.
- din  input  WIDTH  write data.
- dout  output  WIDTH  read data.
- count  output  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- dir  output  NCH  current direction per channel; 1 means up.
- ec  output  NCH  one-cycle end-count pulse per channel.
- err  output  1  one-cycle illegal-access pulse.

Function
REQ-004 Per-channel registers SHALL be:
- a[1:0]=00: LOAD (rw).
- 01: LIMIT (rw).
- 10: CTRL (rw): bit0 dir_init, bit1 reload, bit2 bounce, bit3 en.
- 11: STATUS (ro): bit0 running, bit1 ec_sticky, bit2 dir.
REQ-005 A write SHALL occur on a clk edge with ncs=0, nwr=0, nrd=1, and SHALL update the register at that edge.
REQ-006 A read SHALL occur with ncs=0, nrd=0, nwr=1; dout SHALL present the register one cycle later (registered) and SHALL be 0 in all other cycles.
REQ-007 Reading STATUS SHALL clear ec_sticky at that edge; a STATUS read in the same cycle as a new ec SHALL return 1 and leave the bit set.
REQ-008 Illegal accesses SHALL pulse err for one cycle and SHALL be ignored. Illegal accesses are: a write to STATUS; nwr=0 and nrd=0 together with ncs=0; a write to CTRL while that channel is RUN.
REQ-009 Each channel SHALL have an FSM with states IDLE, RUN and DONE.
REQ-010 When start=1 and en=1, the channel SHALL enter RUN from any state, load count=LOAD and set dir=dir_init, using register values from before that edge.
REQ-011 In RUN, count SHALL step by +1 (dir=1) or -1 (dir=0) every cycle, modulo 2^WIDTH: up from 2^WIDTH-1 wraps to 0, down from 0 wraps to 2^WIDTH-1.
REQ-012 When count==LIMIT in RUN, the next edge SHALL pulse ec and set ec_sticky, then act by mode:
- reload=1: count<=LOAD, stay in RUN.
- bounce=1: toggle dir and step once in the new direction.
- neither set: enter DONE and hold count.
- reload and bounce both set: reload SHALL take priority.
REQ-013 If LOAD==LIMIT, ec SHALL fire on the first cycle after start.
REQ-014 A write to LOAD or LIMIT during RUN SHALL be accepted; LIMIT SHALL apply on the next compare, and LOAD on the next start or reload.
REQ-015 start while en=0 SHALL leave the channel unchanged.
REQ-016 Channels SHALL operate independently, with no cross-channel interaction.

Reset
REQ-017 While rst=1, all of the following SHALL be 0: registers, count, dir, ec, err, dout, ec_sticky; every FSM SHALL be in IDLE.
REQ-018 Reset asserted mid-RUN SHALL abort counting immediately, without waiting for a clock edge.
REQ-019 The first write SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-020 With macro UDC_BOUNCE_EN defined, CTRL.bit2 SHALL implement bounce as in REQ-012.
REQ-021 Without UDC_BOUNCE_EN, CTRL.bit2 SHALL be ignored and SHALL read 0, and a channel with reload=0 SHALL always go to DONE at LIMIT.

Verification
Scenarios assume WIDTH=8, NCH=4.
REQ-022 One-shot up:
- Stimulus: ch0 LOAD=0x05, LIMIT=0x08, CTRL=0x09, then start.
- Response: count 05,06,07,08; ec[0] pulses once; ch0 in DONE holding 0x08; STATUS=0x06.
REQ-023 Down with wrap and auto-reload:
- Stimulus: ch1 LOAD=0x01, LIMIT=0xFE, CTRL=0x0A, then start.
- Response: count 01,00,FF,FE, then 01; ec[1] pulses every 4 cycles.
REQ-024 Bounce (UDC_BOUNCE_EN defined):
- Stimulus: ch2 LOAD=0x10, LIMIT=0x12, CTRL=0x0D, then start.
- Response: count 10,11,12,11,10,0F; dir[2] goes low after 0x12.
REQ-025 Illegal accesses:
- Stimulus: write STATUS; assert nwr and nrd together; write CTRL to ch0 while it is running.
- Response: each gives one err pulse, with registers unchanged.
REQ-026 Reset mid-run:
- Stimulus: assert rst while ch3 is counting at 0x40.
- Response: count[3]=0 with no clock edge; after release, ch3 stays in IDLE until start.
